// File: rtl/vga_timing_ctrl.sv
// -----------------------------------------------------------------------------
// vga_timing_ctrl
//   Timing sequencer for the 25 MHz VGA colour-output stage. Runs the
//   horizontal/vertical counters, presents the pixel coordinate to the colour
//   source (stage 0) and produces blanking enables and sync pulses delayed one
//   clock (stage 1) so they line up with the output stage's colour register.
//   Run/stop control always stops cleanly on a frame boundary.
//
// Ports
//   clk25m       in   pixel clock
//   rst_n        in   synchronous active-low reset
//   run          in   1 = generate frames, 0 = stop at end of current frame
//   px, py       out  stage-0 column / line (equal to hcnt / vcnt)
//   pix_req      out  stage-0: coordinate inside active area
//   hen, ven     out  stage-1 horizontal / vertical active enables
//   hsync, vsync out  stage-1 sync pulses, asserted level SYNC_POL
//   frame_start  out  stage-0 pulse at hcnt=0, vcnt=0
//   line_start   out  stage-0 pulse at hcnt=0 of every line
//   frame_done   out  stage-0 pulse at the last pixel of the frame
//   busy         out  1 whenever the sequencer is not idle
//   dbg_state    out  current FSM state (0 IDLE, 1 RUN, 2 STOPPING)
//
// Handshake: there is none; run is a level. It is sampled every clock and
// only decides whether the next frame boundary ends in IDLE.
// -----------------------------------------------------------------------------
module vga_timing_ctrl #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk25m,
  input  logic       rst_n,
  input  logic       run,
  output logic [9:0] px,
  output logic [9:0] py,
  output logic       pix_req,
  output logic       hen,
  output logic       ven,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic       line_start,
  output logic       frame_done,
  output logic       busy,
  output logic [1:0] dbg_state
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] L_H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] L_H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] L_HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] L_HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] L_V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] L_V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] L_VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] L_VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_STOPPING = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [9:0] r_hcnt;
  logic [9:0] r_vcnt;
  logic       r_hen;
  logic       r_ven;
  logic       r_hsync;
  logic       r_vsync;

  logic w_busy;
  logic w_h_last;
  logic w_v_last;
  logic w_frame_end;
  logic w_h_act;
  logic w_v_act;
  logic w_hs_win;
  logic w_vs_win;

  assign w_busy      = (r_state != S_IDLE);
  assign w_h_last    = (r_hcnt == L_H_LAST);
  assign w_v_last    = (r_vcnt == L_V_LAST);
  assign w_frame_end = w_busy && w_h_last && w_v_last;
  assign w_h_act     = (r_hcnt < L_H_ACT);
  assign w_v_act     = (r_vcnt < L_V_ACT);
  assign w_hs_win    = (r_hcnt >= L_HS_BEG) && (r_hcnt <= L_HS_END);
  assign w_vs_win    = (r_vcnt >= L_VS_BEG) && (r_vcnt <= L_VS_END);

  // Next-state logic. STOPPING keeps counting; run coming back mid-frame
  // simply resumes RUN without touching the counters. If run returns on the
  // very frame_done cycle, RUN wins and the next frame follows back-to-back.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (run) w_state_next = S_RUN;
      S_RUN:      if (!run) w_state_next = S_STOPPING;
      S_STOPPING: begin
        if (run)              w_state_next = S_RUN;
        else if (w_frame_end) w_state_next = S_IDLE;
      end
      default:    w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk25m) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Counters only move outside IDLE. Leaving STOPPING on frame_done lands on
  // 0/0 through the normal wrap, so IDLE always holds zeros.
  always_ff @(posedge clk25m) begin
    if (!rst_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_busy) begin
      if (w_h_last) begin
        r_hcnt <= '0;
        r_vcnt <= w_v_last ? 10'd0 : r_vcnt + 10'd1;
      end else begin
        r_hcnt <= r_hcnt + 10'd1;
      end
    end
  end

  // Stage 1: one clock behind px/py to match the output colour register.
  always_ff @(posedge clk25m) begin
    if (!rst_n) begin
      r_hen   <= 1'b0;
      r_ven   <= 1'b0;
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
    end else begin
      r_hen   <= w_busy && w_h_act;
      r_ven   <= w_busy && w_v_act;
      r_hsync <= (w_busy && w_hs_win) ? SYNC_POL : ~SYNC_POL;
      r_vsync <= (w_busy && w_vs_win) ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign px          = r_hcnt;
  assign py          = r_vcnt;
  assign pix_req     = w_busy && w_h_act && w_v_act;
  assign frame_start = w_busy && (r_hcnt == 10'd0) && (r_vcnt == 10'd0);
  assign line_start  = w_busy && (r_hcnt == 10'd0);
  assign frame_done  = w_frame_end;
  assign busy        = w_busy;
  assign hen         = r_hen;
  assign ven         = r_ven;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign dbg_state   = r_state;

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Sequencer for the 25 MHz VGA colour-output stage.
- Generates horizontal/vertical counters, the pixel coordinate presented to the colour source, the hen/ven blanking enables and the hsync/vsync pulses.
- Enables and syncs are delayed one cycle to match the colour register in the output stage.
- Provides run/stop control with clean frame-boundary stopping, plus frame/line strobes for game logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk25m  in  1  25 MHz pixel clock
- rst_n  in  1  synchronous active-low reset
- run  in  1  1 = generate frames; 0 = stop at end of current frame
- px  out  10  current column (stage 0); equals hcnt
- py  out  10  current line (stage 0); equals vcnt
- pix_req  out  1  stage 0: px/py inside active area, colour source must drive colors3 this cycle
- hen  out  1  stage 1 horizontal active enable
- ven  out  1  stage 1 vertical active enable
- hsync  out  1  stage 1 horizontal sync
- vsync  out  1  stage 1 vertical sync
- frame_start  out  1  one-cycle pulse, stage 0, at hcnt=0, vcnt=0 while RUN
- line_start  out  1  one-cycle pulse, stage 0, at hcnt=0 for every line while RUN
- frame_done  out  1  one-cycle pulse, stage 0, at hcnt=H_TOTAL-1, vcnt=V_TOTAL-1
- busy  out  1  1 when state != IDLE

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Counters: hcnt and vcnt are 10-bit unsigned.
  - hcnt wraps H_TOTAL-1 -> 0 and then vcnt increments.
  - vcnt wraps V_TOTAL-1 -> 0.
  - Defaults must fit 10 bits.
- Reset (rst_n=0 at edge):
  - state=IDLE, hcnt=vcnt=0.
  - pix_req=hen=ven=0; frame_start=line_start=frame_done=0.
  - hsync=vsync=~SYNC_POL; busy=0.
  - Reset mid-frame aborts immediately; no partial-frame completion.
- States:
  - IDLE: counters held at 0, all enables 0, syncs inactive. run=1 -> RUN; the first counted cycle is hcnt=0, vcnt=0 with frame_start=1.
  - RUN: counters advance every clock. run=0 -> STOPPING, and counters continue.
  - STOPPING: counters advance. run=1 re-entry -> RUN with no disturbance to timing. On frame_done cycle -> IDLE, counters return to 0.
  - RUN with run=1 at frame_done: wrap to next frame, no gap.
- Stage 0 (combinational from registered counters and state):
  - pix_req = (hcnt<H_ACTIVE)&&(vcnt<V_ACTIVE)&&state!=IDLE.
  - Strobes are valid only when state!=IDLE.
- Stage 1 (registered one clock after stage 0):
  - hen = prior (hcnt<H_ACTIVE && state!=IDLE).
  - ven = prior (vcnt<V_ACTIVE && state!=IDLE).
  - hsync asserted (=SYNC_POL) when prior hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - vsync asserted when prior vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491, for whole lines.
- Alignment: colors3 driven combinationally from px/py in cycle N is registered by the output stage at end of N. hen/ven for that pixel are high in cycle N+1. Latency px -> hen/ven/syncs = 1 clock.
- Simultaneous run=0 on frame_done cycle while in RUN: go to STOPPING, then the next full frame is output before IDLE.

Test Plan:
- Reset, run=1 -> first cycle after release: px=0, py=0, pix_req=1, frame_start=1, line_start=1; next cycle hen=ven=1.
- Count one line -> pix_req high for exactly 640 clocks; hsync low on stage-1 cycles for prior hcnt 656..751 (96 clocks); line period 800 clocks.
- Count one frame -> ven high 480 lines; vsync low for lines 490..491 (1600 clocks); frame period 420000 clocks; frame_done once at hcnt=799, vcnt=524.
- Drop run at px=100, py=200 -> frame completes through hcnt=799, vcnt=524, then IDLE. Then px=py=0, hen=ven=0, hsync=vsync=1, busy=0 held.
- Drop run, restore it at py=300 -> no timing discontinuity, next frame starts back-to-back, frame_start at 420000-clock spacing.
- Assert rst_n=0 at px=400, py=250 -> next cycle all outputs at reset values; release with run=1 restarts at px=0, py=0 with frame_start=1.
